// File: rtl/fp_pkg.sv
// Shared definitions for the FP32 operand loader: FSM states, FP32 field layout, flush helper.
// Optional feature macro: FP_LOADER_FTZ_EN (flush denormal operands to signed zero).
package fp_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } fp_state_e;

    localparam int SIGN_BIT     = 31;
    localparam int EXP_MSB      = 30;
    localparam int EXP_LSB      = 23;
    localparam int FRAC_W       = 23;
    localparam int BYTES_PER_OP = 4;

    // Zero exponent means denormal (or zero): clear the fraction, keep the sign.
    function automatic logic [31:0] flush_denormal(input logic [31:0] x);
        logic [31:0] r;
        r = x;
        if (x[EXP_MSB:EXP_LSB] == 8'h00) begin
            r[FRAC_W-1:0] = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_idle_timer.sv
// Counts idle cycles while enabled; 'expired' fires in the cycle the count reaches LIMIT.
module fp_idle_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    assign expired = enable && !clear && (count_q == LAST);

    // Self-clearing on expiry so the next partial pair starts a fresh count.
    always_comb begin
        count_d = count_q;
        if (clear || expired) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fp_operand_loader.sv
// Assembles a little-endian byte stream into an FP32 operand pair (A then B) for a multiplier.
// Optional feature macro: FP_LOADER_FTZ_EN (denormal operands presented as signed zero).
module fp_operand_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_valid,
    input  logic        op_ready,
    output logic        timeout_err,
    output logic [1:0]  dbg_state_o
);
    import fp_pkg::*;

    // Handshakes: a byte moves when in_valid && in_ready at a rising edge;
    // a pair moves when op_valid && op_ready. Valid holds its payload until taken.

    fp_state_e   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] a_sh_q, a_sh_d;
    logic [23:0] b_sh_q, b_sh_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic        op_valid_q, op_valid_d;
    logic        timeout_q, timeout_d;
    logic        accept;
    logic        partial;
    logic        expired;

    function automatic logic [31:0] present_op(input logic [31:0] x);
`ifdef FP_LOADER_FTZ_EN
        return flush_denormal(x);
`else
        return x;
`endif
    endfunction

    assign in_ready    = rst_n && (state_q != PRESENT);
    assign accept      = in_valid && in_ready;
    assign partial     = ((state_q == LOAD_A) && (cnt_q != 2'd0)) || (state_q == LOAD_B);
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign op_valid    = op_valid_q;
    assign timeout_err = timeout_q;
    assign dbg_state_o = state_q;

    fp_idle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_idle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (partial && !accept),
        .clear   (accept || !partial),
        .expired (expired)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_valid_d = op_valid_q;
        timeout_d  = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (accept) begin
                    a_sh_d[{cnt_q, 3'b000} +: 8] = in_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = LOAD_B;
                end else if (expired) begin
                    cnt_d     = 2'd0;
                    timeout_d = 1'b1;
                end
            end
            LOAD_B: begin
                if (accept) begin
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0: b_sh_d[7:0]   = in_data;
                        2'd1: b_sh_d[15:8]  = in_data;
                        2'd2: b_sh_d[23:16] = in_data;
                        default: begin
                            // Last byte goes straight to the output register.
                            op_a_d     = present_op(a_sh_q);
                            op_b_d     = present_op({in_data, b_sh_q});
                            op_valid_d = 1'b1;
                            state_d    = PRESENT;
                        end
                    endcase
                end else if (expired) begin
                    state_d   = LOAD_A;
                    cnt_d     = 2'd0;
                    timeout_d = 1'b1;
                end
            end
            PRESENT: begin
                if (op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD_A;
            cnt_q      <= 2'd0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule
